next_pc_ctrl: RTL and testbench

Next-PC controller for the pipelined MIPS fetch stage. It drives the program counter register's `PCWriteValue` and `PCWrite` inputs and receives the current `pc` back from that register. Each cycle it chooses between sequential fetch (pc+4), a jump from ID, a taken branch from EX and an exception vector. It also honours load-use stalls and instruction-memory wait states. Redirects that arrive while the fetch is blocked are held in a small pending-redirect state machine until the fetch can accept them.

---
 rtl/next_pc_ctrl.sv | 106 ++++++++++
 tb/tb_next_pc_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/next_pc_ctrl.sv
// rtl/next_pc_ctrl.sv - next-PC select for the fetch stage with a pending-redirect holding FSM
module next_pc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        exc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] PCWriteValue,
    output logic        PCWrite,
    output logic        if_flush,
    output logic        redirect_pending
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        PEND_BR  = 2'b01,
        PEND_EXC = 2'b10
    } state_t;

    state_t      state, next_state;
    logic [31:0] pending_target, next_target;
    logic [31:0] seq_pc, br_aligned, jump_aligned;

    assign seq_pc       = pc + 32'd4;
    assign br_aligned   = br_target & ~32'h3;
    assign jump_aligned = jump_target & ~32'h3;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            pending_target <= 32'h0;
        end else begin
            state          <= next_state;
            pending_target <= next_target;
        end
    end

    always_comb begin
        next_state   = state;
        next_target  = pending_target;
        PCWrite      = 1'b0;
        PCWriteValue = seq_pc;
        if_flush     = 1'b0;

        if (rst) begin
            PCWriteValue = 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (imem_ready) begin
                        if (exc) begin
                            PCWrite      = 1'b1;
                            PCWriteValue = EXC_VECTOR;
                            if_flush     = 1'b1;
                        end else if (br_taken) begin
                            PCWrite      = 1'b1;
                            PCWriteValue = br_aligned;
                            if_flush     = 1'b1;
                        end else if (jump && !stall) begin
                            PCWrite      = 1'b1;
                            PCWriteValue = jump_aligned;
                            if_flush     = 1'b1;
                        end else if (!stall) begin
                            PCWrite      = 1'b1;
                            PCWriteValue = seq_pc;
                        end
                    end else if (exc) begin
                        next_state  = PEND_EXC;
                        next_target = EXC_VECTOR;
                    end else if (br_taken) begin
                        next_state  = PEND_BR;
                        next_target = br_aligned;
                    end else if (jump) begin
                        // Jumps share the branch slot; ID may not re-present it later.
                        next_state  = PEND_BR;
                        next_target = jump_aligned;
                    end
                end
                PEND_BR, PEND_EXC: begin
                    if (imem_ready) begin
                        PCWrite      = 1'b1;
                        PCWriteValue = exc ? EXC_VECTOR : pending_target;
                        if_flush     = 1'b1;
                        next_state   = IDLE;
                    end else if (state == PEND_BR && exc) begin
                        next_state  = PEND_EXC;
                        next_target = EXC_VECTOR;
                    end
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    assign redirect_pending = (state != IDLE);

endmodule

// File: tb/tb_next_pc_ctrl.sv
// tb/tb_next_pc_ctrl.sv - scoreboard bench for next_pc_ctrl with directed vectors
module tb_next_pc_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        stall;
    logic        imem_ready;
    logic        exc;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] PCWriteValue;
    logic        PCWrite;
    logic        if_flush;
    logic        redirect_pending;

    typedef struct {
        logic        we;
        logic [31:0] val;
        logic        flush;
        logic        pend;
        logic        chk_val;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   vec_id   = 0;
    bit   stim_done = 0;

    next_pc_ctrl #(.EXC_VECTOR(32'h0000_0180)) dut (
        .clk              (clk),
        .rst              (rst),
        .pc               (pc),
        .stall            (stall),
        .imem_ready       (imem_ready),
        .exc              (exc),
        .br_taken         (br_taken),
        .br_target        (br_target),
        .jump             (jump),
        .jump_target      (jump_target),
        .PCWriteValue     (PCWriteValue),
        .PCWrite          (PCWrite),
        .if_flush         (if_flush),
        .redirect_pending (redirect_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: the DUT presents a decision every cycle; compare at the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (PCWrite !== e.we) begin
                n_fail++;
                $display("FAIL v%0d PCWrite: got %b want %b", e.id, PCWrite, e.we);
            end
            n_checks++;
            if (if_flush !== e.flush) begin
                n_fail++;
                $display("FAIL v%0d if_flush: got %b want %b", e.id, if_flush, e.flush);
            end
            n_checks++;
            if (redirect_pending !== e.pend) begin
                n_fail++;
                $display("FAIL v%0d redirect_pending: got %b want %b", e.id, redirect_pending, e.pend);
            end
            if (e.chk_val) begin
                n_checks++;
                if (PCWriteValue !== e.val) begin
                    n_fail++;
                    $display("FAIL v%0d PCWriteValue: got %h want %h", e.id, PCWriteValue, e.val);
                end
            end
        end
    end

    task automatic step(input logic r, input logic [31:0] p, input logic st, input logic im,
                        input logic ex, input logic br, input logic [31:0] bt,
                        input logic jp, input logic [31:0] jt,
                        input logic ewe, input logic [31:0] eval, input logic efl,
                        input logic epd, input logic ecv);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; pc = p; stall = st; imem_ready = im; exc = ex;
        br_taken = br; br_target = bt; jump = jp; jump_target = jt;
        vec_id++;
        e.we = ewe; e.val = eval; e.flush = efl; e.pend = epd; e.chk_val = ecv; e.id = vec_id;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; pc = 32'h0; stall = 1'b0; imem_ready = 1'b0; exc = 1'b0;
        br_taken = 1'b0; br_target = 32'h0; jump = 1'b0; jump_target = 32'h0;
        @(posedge clk);
        //    rst pc            st im ex br bt       jp jt         we val           fl pd cv
        step(1, 32'h0,         0, 1, 0, 0, 32'h0,   0, 32'h0,     0, 32'h0,        0, 0, 1);
        // sequential fetch
        step(0, 32'h0,         0, 1, 0, 0, 32'h0,   0, 32'h0,     1, 32'h4,        0, 0, 1);
        step(0, 32'h4,         0, 1, 0, 0, 32'h0,   0, 32'h0,     1, 32'h8,        0, 0, 1);
        step(0, 32'h8,         0, 1, 0, 0, 32'h0,   0, 32'h0,     1, 32'hC,        0, 0, 1);
        step(0, 32'hFFFF_FFFC, 0, 1, 0, 0, 32'h0,   0, 32'h0,     1, 32'h0,        0, 0, 1);
        // priority and stall
        step(0, 32'h0,         1, 1, 1, 1, 32'h40,  1, 32'h1003,  1, 32'h180,      1, 0, 1);
        step(0, 32'h180,       1, 1, 0, 0, 32'h0,   1, 32'h1003,  0, 32'h0,        0, 0, 0);
        step(0, 32'h180,       0, 1, 0, 0, 32'h0,   1, 32'h1003,  1, 32'h1000,     1, 0, 1);
        // latch branch, overwrite with exception
        step(0, 32'h1000,      0, 0, 0, 1, 32'h200, 0, 32'h0,     0, 32'h0,        0, 0, 0);
        step(0, 32'h1000,      0, 0, 0, 0, 32'h0,   0, 32'h0,     0, 32'h0,        0, 1, 0);
        step(0, 32'h1000,      0, 0, 1, 0, 32'h0,   0, 32'h0,     0, 32'h0,        0, 1, 0);
        step(0, 32'h1000,      0, 1, 0, 0, 32'h0,   0, 32'h0,     1, 32'h180,      1, 1, 1);
        step(0, 32'h180,       0, 1, 0, 0, 32'h0,   0, 32'h0,     1, 32'h184,      0, 0, 1);
        // pending branch keeps first target
        step(0, 32'h184,       0, 0, 0, 1, 32'h200, 0, 32'h0,     0, 32'h0,        0, 0, 0);
        step(0, 32'h184,       0, 0, 0, 0, 32'h0,   1, 32'h300,   0, 32'h0,        0, 1, 0);
        step(0, 32'h184,       0, 0, 0, 1, 32'h500, 0, 32'h0,     0, 32'h0,        0, 1, 0);
        step(0, 32'h184,       1, 1, 0, 1, 32'h600, 1, 32'h700,   1, 32'h200,      1, 1, 1);
        // reset mid-pending
        step(0, 32'h200,       0, 0, 0, 1, 32'h200, 0, 32'h0,     0, 32'h0,        0, 0, 0);
        step(1, 32'h200,       0, 1, 1, 0, 32'h0,   0, 32'h0,     0, 32'h0,        0, 1, 1);
        step(0, 32'h0,         0, 1, 0, 0, 32'h0,   0, 32'h0,     1, 32'h4,        0, 0, 1);
        // jump latched during wait, target aligned
        step(0, 32'h4,         1, 0, 0, 0, 32'h0,   1, 32'h303,   0, 32'h0,        0, 0, 0);
        step(0, 32'h4,         0, 1, 0, 0, 32'h0,   0, 32'h0,     1, 32'h300,      1, 1, 1);
        step(0, 32'h300,       0, 1, 0, 0, 32'h0,   0, 32'h0,     1, 32'h304,      0, 0, 1);
        stim_done = 1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d entries left want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
